// File: rtl/cordic_pkg.sv
// cordic_pkg: shared defaults, Q7.11 angle constants and FSM encodings for the CORDIC angle feeder.
package cordic_pkg;
  localparam int DEF_WORD_LENGTH = 18;
  localparam int DEF_TIMEOUT_CYCLES = 32;
  localparam int PI = 32'h1922;
  localparam int PI_HALF = 32'h0C90;
  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT} state_e;
endpackage

// File: rtl/cordic_req_fifo.sv
// cordic_req_fifo: two-entry request buffer with simultaneous push/pop.
module cordic_req_fifo #(
  parameter int WIDTH = 54
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o
);
  logic [WIDTH-1:0] mem_q [2];
  logic             wr_q, rd_q;
  logic [1:0]       cnt_q;
  logic             push, pop;
  assign full_o  = cnt_q == 2'd2;
  assign empty_o = cnt_q == 2'd0;
  assign push    = push_i & ~full_o;
  assign pop     = pop_i & ~empty_o;
  assign dout_o  = mem_q[rd_q];
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_q  <= 1'b0;
      rd_q  <= 1'b0;
      cnt_q <= 2'd0;
    end else begin
      wr_q  <= wr_q ^ push;
      rd_q  <= rd_q ^ pop;
      cnt_q <= cnt_q + 2'(push) - 2'(pop);
    end
  end
  always_ff @(posedge clk_i)
    if (push) mem_q[wr_q] <= din_i;
endmodule

// File: rtl/cordic_angle_feeder.sv
// cordic_angle_feeder: range-reduces rotation requests into [-pi/2, +pi/2], queues them
// and issues them one at a time to a rotational CORDIC with done/timeout handshake.
module cordic_angle_feeder
  import cordic_pkg::*;
#(
  parameter int WORD_LENGTH    = DEF_WORD_LENGTH,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   IN_VALID,
  output logic                   IN_READY,
  input  logic [WORD_LENGTH-1:0] X_IN,
  input  logic [WORD_LENGTH-1:0] Y_IN,
  input  logic [WORD_LENGTH-1:0] Z_IN,
  output logic                   ENABLE,
  output logic [WORD_LENGTH-1:0] Xo,
  output logic [WORD_LENGTH-1:0] Yo,
  output logic [WORD_LENGTH-1:0] Zo,
  input  logic                   CORDIC_DONE,
  output logic                   BUSY,
  output logic                   RANGE_ERR,
  output logic                   TIMEOUT
);
  localparam int W  = WORD_LENGTH;
  localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
  typedef logic signed [W-1:0] word_t;
  localparam word_t PI_W  = word_t'(PI);
  localparam word_t PH_W  = word_t'(PI_HALF);
  localparam word_t MAX_W = {1'b0, {(W-1){1'b1}}};
  localparam word_t MIN_W = {1'b1, {(W-1){1'b0}}};

  function automatic word_t sat_neg(input word_t v);
    return (v == MIN_W) ? MAX_W : -v;
  endfunction

  state_e        state_q, state_d;
  logic [CW-1:0] tmo_q, tmo_d;
  logic          to_d, to_q, rerr_q, init_q;
  word_t         x, y, z, xr, yr, zr;
  word_t         x_q, y_q, z_q;
  logic          hi, lo, in_range, accept, push, pop, full, empty;
  logic [3*W-1:0] head;

  always_comb begin
    x        = word_t'(X_IN);
    y        = word_t'(Y_IN);
    z        = word_t'(Z_IN);
    hi       = z > PH_W;
    lo       = z < -PH_W;
    in_range = (z <= PI_W) && (z >= -PI_W);
    xr       = (hi || lo) ? sat_neg(x) : x;
    yr       = (hi || lo) ? sat_neg(y) : y;
    zr       = hi ? z - PI_W : lo ? z + PI_W : z;
  end

  assign IN_READY  = init_q & ~full;
  assign accept    = IN_VALID & IN_READY;
  assign push      = accept & in_range;
  assign pop       = (state_q == ST_IDLE) & ~empty;
  assign ENABLE    = state_q == ST_ISSUE;
  assign BUSY      = state_q != ST_IDLE;
  assign RANGE_ERR = rerr_q;
  assign TIMEOUT   = to_q;
  assign Xo        = x_q;
  assign Yo        = y_q;
  assign Zo        = z_q;

  cordic_req_fifo #(.WIDTH(3*W)) u_fifo (
    .clk_i  (CLK),
    .rst_ni (RST),
    .push_i (push),
    .pop_i  (pop),
    .din_i  ({xr, yr, zr}),
    .dout_o (head),
    .full_o (full),
    .empty_o(empty)
  );

  // CORDIC_DONE is only looked at in WAIT and wins over an expiring count.
  always_comb begin
    state_d = state_q;
    tmo_d   = tmo_q;
    to_d    = 1'b0;
    case (state_q)
      ST_IDLE:  state_d = empty ? ST_IDLE : ST_ISSUE;
      ST_ISSUE: begin
        state_d = ST_WAIT;
        tmo_d   = '0;
      end
      ST_WAIT: begin
        to_d    = !CORDIC_DONE && (tmo_q == CW'(TIMEOUT_CYCLES - 1));
        state_d = (CORDIC_DONE || to_d) ? ST_IDLE : ST_WAIT;
        tmo_d   = tmo_q + CW'(1);
      end
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q <= ST_IDLE;
      tmo_q   <= '0;
      to_q    <= 1'b0;
      rerr_q  <= 1'b0;
      init_q  <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
    end else begin
      state_q <= state_d;
      tmo_q   <= tmo_d;
      to_q    <= to_d;
      rerr_q  <= accept & ~in_range;
      init_q  <= 1'b1;
      if (pop) {x_q, y_q, z_q} <= head;
    end
  end
endmodule

// File: tb/tb_cordic_angle_feeder.sv
// tb_cordic_angle_feeder: directed checks of reduction, queuing, issue timing, timeout and reset.
module tb_cordic_angle_feeder;
  logic        CLK = 1'b0, RST = 1'b0, IN_VALID = 1'b0, CORDIC_DONE = 1'b0;
  logic [17:0] X_IN = '0, Y_IN = '0, Z_IN = '0;
  logic        IN_READY, ENABLE, BUSY, RANGE_ERR, TIMEOUT;
  logic [17:0] Xo, Yo, Zo;
  int          errors = 0, checks = 0;
  int          sent, issued, cd;
  logic        acc, saw_full, seen;

  cordic_angle_feeder dut (
    .CLK(CLK), .RST(RST), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .X_IN(X_IN), .Y_IN(Y_IN), .Z_IN(Z_IN), .ENABLE(ENABLE),
    .Xo(Xo), .Yo(Yo), .Zo(Zo), .CORDIC_DONE(CORDIC_DONE),
    .BUSY(BUSY), .RANGE_ERR(RANGE_ERR), .TIMEOUT(TIMEOUT)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [53:0] vec(input int i);
    return {18'(i + 1), 18'(32'h100 + i), 18'(16 * i)};
  endfunction

  task automatic send(input logic [17:0] x, input logic [17:0] y, input logic [17:0] z);
    IN_VALID = 1'b1;
    X_IN = x;
    Y_IN = y;
    Z_IN = z;
    tick();
    IN_VALID = 1'b0;
  endtask

  task automatic rot(input string tag, input logic [17:0] x, y, z, ex, ey, ez);
    send(x, y, z);
    chk({tag, "_en_early"}, ENABLE, 1'b0);
    tick();
    chk({tag, "_en"}, ENABLE, 1'b1);
    chk({tag, "_xyz"}, {Xo, Yo, Zo}, {ex, ey, ez});
    CORDIC_DONE = 1'b1;
    tick();
    CORDIC_DONE = 1'b0;
    chk({tag, "_wait_busy"}, {BUSY, ENABLE}, 2'b10);
    CORDIC_DONE = 1'b1;
    tick();
    CORDIC_DONE = 1'b0;
    chk({tag, "_done_idle"}, {BUSY, ENABLE, TIMEOUT}, 3'b000);
    chk({tag, "_hold"}, {Xo, Yo, Zo}, {ex, ey, ez});
  endtask

  initial begin
    tick();
    tick();
    chk("rst_outs", {IN_READY, ENABLE, BUSY, RANGE_ERR, TIMEOUT}, 5'b0);
    chk("rst_xyz", {Xo, Yo, Zo}, 54'd0);
    RST = 1'b1;
    tick();
    chk("ready_after_rst", IN_READY, 1'b1);

    rot("pihalf", 18'h00800, 18'h01000, 18'h00C90, 18'h00800, 18'h01000, 18'h00C90);
    rot("3pi4", 18'h01800, 18'h02000, 18'h012D9, 18'h3E800, 18'h3E000, 18'h3F9B7);
    rot("negpi", 18'h01800, 18'h02000, 18'h3E6DE, 18'h3E800, 18'h3E000, 18'h00000);
    rot("sat", 18'h20000, 18'h00001, 18'h3F000, 18'h1FFFF, 18'h3FFFF, 18'h00922);

    send(18'h00100, 18'h00200, 18'h01923);
    chk("rerr_pulse", RANGE_ERR, 1'b1);
    chk("rerr_occ", dut.u_fifo.cnt_q, 2'd0);
    tick();
    chk("rerr_once", {RANGE_ERR, ENABLE, BUSY}, 3'b000);
    tick();
    chk("rerr_no_issue", {ENABLE, BUSY, IN_READY}, 3'b001);

    sent = 0;
    issued = 0;
    cd = 0;
    saw_full = 1'b0;
    IN_VALID = 1'b1;
    {X_IN, Y_IN, Z_IN} = vec(0);
    for (int c = 0; c < 300 && !(issued == 4 && cd == 0); c++) begin
      acc = IN_VALID && IN_READY;
      tick();
      CORDIC_DONE = 1'b0;
      if (acc) sent++;
      if (ENABLE) begin
        chk("b2b_one_en_per_done", cd, 0);
        chk("b2b_order", {Xo, Yo, Zo}, vec(issued));
        issued++;
        cd = 20;
      end
      chk("b2b_ready", IN_READY, (sent - issued) < 2);
      if (sent - issued == 2) saw_full = 1'b1;
      if (cd > 0) begin
        cd--;
        CORDIC_DONE = (cd == 0);
      end
      IN_VALID = sent < 4;
      {X_IN, Y_IN, Z_IN} = vec(sent);
    end
    IN_VALID = 1'b0;
    tick();
    CORDIC_DONE = 1'b0;
    chk("b2b_issued", issued, 4);
    chk("b2b_full_seen", saw_full, 1'b1);
    tick();
    chk("b2b_idle", {BUSY, ENABLE, TIMEOUT}, 3'b000);

    IN_VALID = 1'b1;
    {X_IN, Y_IN, Z_IN} = vec(7);
    tick();
    {X_IN, Y_IN, Z_IN} = vec(8);
    tick();
    IN_VALID = 1'b0;
    chk("tmo_first_en", {ENABLE, Xo, Yo, Zo}, {1'b1, vec(7)});
    for (int i = 1; i <= 33; i++) begin
      tick();
      chk("tmo_pulse_time", TIMEOUT, i == 33);
    end
    tick();
    chk("tmo_next_issue", {TIMEOUT, ENABLE, Xo, Yo, Zo}, {2'b01, vec(8)});

    tick();
    send(18'h00003, 18'h00004, 18'h00005);
    chk("rst_mid_wait_pre", BUSY, 1'b1);
    RST = 1'b0;
    tick();
    RST = 1'b1;
    chk("rst_mid_outs", {IN_READY, ENABLE, BUSY, RANGE_ERR, TIMEOUT}, 5'b0);
    chk("rst_mid_xyz", {Xo, Yo, Zo}, 54'd0);
    tick();
    chk("rst_mid_ready", IN_READY, 1'b1);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      seen |= ENABLE | TIMEOUT | BUSY;
    end
    chk("rst_mid_discard", seen, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/cordic_angle_feeder.md
CORDIC_ANGLE_FEEDER -- requirements
Module: cordic_angle_feeder

Interface
REQ-001 SHALL have parameter WORD_LENGTH, default 18, width of all X/Y/Z buses, signed two's complement Q7.11 (1.0 = 0x00800).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 32, maximum WAIT-state cycles before abandoning a rotation.
REQ-003 SHALL have port CLK  input  1  single clock; all state updates on the rising edge.
REQ-004 SHALL have port RST  input  1  reset; synchronous, active-low.
REQ-005 SHALL have port IN_VALID  input  1  upstream request valid.
REQ-006 SHALL have port IN_READY  output  1  feeder can accept a request this cycle.
REQ-007 SHALL have ports X_IN, Y_IN, Z_IN  input  WORD_LENGTH each  vector and angle in radians, Z range [-pi, +pi].
REQ-008 SHALL have port ENABLE  output  1  one-cycle start pulse to the rotational CORDIC.
REQ-009 SHALL have ports Xo, Yo, Zo  output  WORD_LENGTH each  range-reduced operands to the CORDIC.
REQ-010 SHALL have port CORDIC_DONE  input  1  one-cycle completion pulse from the CORDIC.
REQ-011 SHALL have port BUSY  output  1  high in ISSUE or WAIT.
REQ-012 SHALL have ports RANGE_ERR, TIMEOUT  output  1 each  one-cycle error pulses.

Function
REQ-013 SHALL accept a request on a rising edge where IN_VALID and IN_READY are both high.
REQ-014 SHALL reduce each accepted request into [-pi/2, +pi/2] before storage: Z > PI_HALF (0x00C90) -> Z-PI, X and Y negated; Z < -PI_HALF -> Z+PI, X and Y negated; otherwise unchanged; PI = 0x01922.
REQ-015 SHALL saturate negation of the most negative value (0x20000) to 0x1FFFF.
REQ-016 SHALL reject a request with Z outside [-PI, +PI]: pulse RANGE_ERR the cycle after acceptance, store nothing, issue nothing.
REQ-017 SHALL buffer reduced requests in a 2-entry FIFO; IN_READY = not full, from the registered occupancy only.
REQ-018 SHALL allow push and pop on the same edge, occupancy unchanged.
REQ-019 SHALL implement FSM IDLE -> ISSUE (FIFO non-empty) -> WAIT (unconditional) -> IDLE (CORDIC_DONE high or timeout).
REQ-020 SHALL in ISSUE drive ENABLE high for exactly one cycle, pop the FIFO head and load it into Xo/Yo/Zo registers.
REQ-021 SHALL hold Xo/Yo/Zo stable from ISSUE until the next ISSUE.
REQ-022 SHALL give latency: request accepted at edge N into an empty FIFO with FSM IDLE -> ENABLE high during cycle N+1 to N+2.
REQ-023 SHALL count WAIT cycles; when the count reaches TIMEOUT_CYCLES without CORDIC_DONE, pulse TIMEOUT for one cycle and return to IDLE.
REQ-024 SHALL ignore CORDIC_DONE outside WAIT.
REQ-025 SHALL give CORDIC_DONE priority over timeout on the same edge (no TIMEOUT pulse).

Reset
REQ-026 SHALL, on a rising edge with RST low, set FSM to IDLE, flush the FIFO, clear the timeout counter, and drive IN_READY=0, ENABLE=0, BUSY=0, RANGE_ERR=0, TIMEOUT=0, Xo=Yo=Zo=0.
REQ-027 SHALL, on reset asserted mid-WAIT, discard the outstanding rotation with no TIMEOUT pulse; IN_READY=1 from the first edge with RST high.

Structure
REQ-028 SHALL place WORD_LENGTH, PI, PI_HALF, TIMEOUT_CYCLES defaults and FSM state encodings in shared package cordic_pkg.
REQ-029 SHALL implement the FIFO as sub-module cordic_req_fifo (depth 2, width 3*WORD_LENGTH).

Verification
REQ-030 SHALL cover: X=0x00800, Y=0x01000, Z=0x00C90 -> single ENABLE one cycle after acceptance, Xo=0x00800, Yo=0x01000, Zo=0x00C90.
REQ-031 SHALL cover: X=0x01800, Y=0x02000, Z=0x012D9 (3pi/4) -> Xo=0x3E800, Yo=0x3E000, Zo=0x3F9B7; and Z=0x3E6DE (-pi) -> Zo=0x00000, X/Y negated.
REQ-032 SHALL cover: Z=0x01923 -> RANGE_ERR one cycle, no ENABLE, FIFO occupancy 0.
REQ-033 SHALL cover: four back-to-back requests, CORDIC_DONE delayed 20 cycles -> IN_READY low while FIFO full, all four issued in order, one ENABLE per CORDIC_DONE.
REQ-034 SHALL cover: CORDIC_DONE never asserted -> TIMEOUT pulse exactly 32 cycles after entering WAIT, next FIFO entry then issued.
REQ-035 SHALL cover: RST low for one edge during WAIT with one entry queued -> all outputs at reset values, queued entry never issued.
